// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for sram_arbiter: acquisition write port, host readback port and busy flag.
// The arbiter takes the slave modport; requesters (or a testbench) take the master modport.
interface sram_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          wreq;
  logic          wbank;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wack;
  logic          rreq;
  logic          rbank;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          rack;
  logic          busy;

  modport master (
    output wreq, wbank, waddr, wdata, rreq, rbank, raddr,
    input  wack, rdata, rack, busy
  );

  modport slave (
    input  wreq, wbank, waddr, wdata, rreq, rbank, raddr,
    output wack, rdata, rack, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares two 2Kx8 SRAM chips between the acquisition writer and the host readback path.
// Define SRAM_ARB_STARVE_EN to let a pending read win after MAX_WBURST back-to-back write grants.
module sram_arbiter #(
  parameter int AW         = 11,
  parameter int DW         = 8,
  parameter int WR_CYC     = 2,
  parameter int RD_CYC     = 2,
  parameter int MAX_WBURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave bus,
  output logic [AW-1:0] address,
  output logic [DW-1:0] outdata,
  output logic          data_oe,
  input  logic [DW-1:0] indata,
  output logic          wr,
  output logic          rd,
  output logic          enout1,
  output logic          enout2
);

  typedef enum logic [2:0] {
    IDLE,
    WSETUP,
    WPULSE,
    WHOLD,
    RSTROBE,
    RDONE
  } state_t;

  localparam int CMAX = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  if (WR_CYC < 1 || RD_CYC < 1 || MAX_WBURST < 1) begin : g_param_check
    $error("sram_arbiter: WR_CYC, RD_CYC and MAX_WBURST must all be at least 1");
  end

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          bank, nxt_bank;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_data;
  logic [DW-1:0] nxt_rdata;
  logic          starve;
  logic          n_wr, n_rd, n_oe, n_en1, n_en2, n_wack, n_rack, n_busy, n_sel;

`ifdef SRAM_ARB_STARVE_EN
  localparam int BW = $clog2(MAX_WBURST + 1);
  logic [BW-1:0] burst;

  assign starve = bus.rreq && (burst == BW'(MAX_WBURST));

  // Counts write grants issued while a read is waiting; any read grant or idle read line clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst <= '0;
    end else if (state == IDLE) begin
      if (nxt_state == RSTROBE || !bus.rreq) begin
        burst <= '0;
      end else if (nxt_state == WSETUP) begin
        burst <= burst + 1'b1;
      end
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Next-state logic; every output is decoded from the next state so the pins come straight off flops.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_bank  = bank;
    nxt_addr  = address;
    nxt_data  = outdata;
    nxt_rdata = bus.rdata;
    case (state)
      IDLE: begin
        if (bus.wreq && !starve) begin
          nxt_state = WSETUP;
          nxt_bank  = bus.wbank;
          nxt_addr  = bus.waddr;
          nxt_data  = bus.wdata;
        end else if (bus.rreq) begin
          nxt_state = RSTROBE;
          nxt_bank  = bus.rbank;
          nxt_addr  = bus.raddr;
          nxt_cnt   = '0;
        end
      end
      WSETUP: begin
        nxt_state = WPULSE;
        nxt_cnt   = '0;
      end
      WPULSE: begin
        if (cnt == CW'(WR_CYC - 1)) begin
          nxt_state = WHOLD;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      WHOLD: nxt_state = IDLE;
      RSTROBE: begin
        if (cnt == CW'(RD_CYC - 1)) begin
          nxt_state = RDONE;
          nxt_rdata = indata;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      RDONE:   nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    n_busy = (nxt_state != IDLE);
    n_wr   = (nxt_state != WPULSE);
    n_rd   = (nxt_state != RSTROBE);
    n_oe   = (nxt_state == WSETUP) || (nxt_state == WPULSE) || (nxt_state == WHOLD);
    n_sel  = n_oe || (nxt_state == RSTROBE);
    n_en1  = !(n_sel && !nxt_bank);
    n_en2  = !(n_sel && nxt_bank);
    n_wack = (nxt_state == WHOLD);
    n_rack = (nxt_state == RDONE);
  end

  // State and registered pins; reset drops every strobe at once, even mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bank      <= 1'b0;
      address   <= '0;
      outdata   <= '0;
      bus.rdata <= '0;
      wr        <= 1'b1;
      rd        <= 1'b1;
      enout1    <= 1'b1;
      enout2    <= 1'b1;
      data_oe   <= 1'b0;
      bus.wack  <= 1'b0;
      bus.rack  <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      bank      <= nxt_bank;
      address   <= nxt_addr;
      outdata   <= nxt_data;
      bus.rdata <= nxt_rdata;
      wr        <= n_wr;
      rd        <= n_rd;
      enout1    <= n_en1;
      enout2    <= n_en2;
      data_oe   <= n_oe;
      bus.wack  <= n_wack;
      bus.rack  <= n_rack;
      bus.busy  <= n_busy;
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the two external 2K×8 SRAM chips between the acquisition writer (the ADC-to-SRAM conversion controller) and a readback requester (host dump path). It accepts level requests from both sides, latches address/bank/data on grant, and generates the SRAM strobes: shared address and data, active-low write, read and chip enables. It sits between the conversion controller and the SRAMs, replacing the controller's direct drive of address, wr and enout1/enout2.

## Interface
- AW, 11, SRAM address width
- DW, 8, SRAM data width
- WR_CYC, 2, cycles the write strobe is held low (≥1)
- RD_CYC, 2, cycles the read strobe is held low before sampling (≥1)
- MAX_WBURST, 4, consecutive write grants allowed while a read is pending (guard build only)

- CLK  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wreq  in  1  write request, level, held until wack
- wbank  in  1  0 = chip 1 (enout1), 1 = chip 2 (enout2)
- waddr  in  AW  write address
- wdata  in  DW  write data
- wack  out  1  one-cycle pulse: write completed
- rreq  in  1  read request, level, held until rack
- rbank  in  1  chip select for read, as wbank
- raddr  in  AW  read address
- rdata  out  DW  read data, valid with rack and held until next read
- rack  out  1  one-cycle pulse: rdata valid
- busy  out  1  high whenever state ≠ IDLE
- address  out  AW  SRAM address
- outdata  out  DW  SRAM write data
- data_oe  out  1  high: drive outdata onto SRAM data bus (tristate outside)
- indata  in  DW  SRAM data bus readback
- wr  out  1  SRAM write strobe, active low
- rd  out  1  SRAM output enable, active low
- enout1  out  1  chip 1 enable, active low
- enout2  out  1  chip 2 enable, active low

## Operation
- FSM: IDLE, WSETUP, WPULSE, WHOLD, RSTROBE, RDONE.
- IDLE: all strobes inactive. Sample requests; on grant latch bank/address(/data) and go to WSETUP or RSTROBE.
- Arbitration: both requests in the same cycle → write wins (see Configuration).
- WSETUP (1 cycle): address, outdata, data_oe=1, selected enable low, wr=1.
- WPULSE (WR_CYC cycles): wr=0.
- WHOLD (1 cycle): wr=1, enable and data still driven; wack=1; → IDLE.
- RSTROBE (RD_CYC cycles): selected enable low, rd=0, data_oe=0; on last cycle's edge indata → rdata.
- RDONE (1 cycle): rd=1, enable high, rack=1; → IDLE.
- Exactly one of enout1/enout2 low during a transaction; never both.
- wr and rd never low together; data_oe never high while rd low.
- Every transaction returns to IDLE for ≥1 cycle (bus turnaround). A request still high after its ack starts a new transaction.
- Inputs other than req are only sampled at grant; changes afterwards are ignored.
- All outputs registered.

## Timing
- Reset (asynchronous, immediate): state IDLE, wr=1, rd=1, enout1=1, enout2=1, data_oe=0, wack=0, rack=0, busy=0, address=0, outdata=0, rdata=0, burst counter=0.
- Reset mid-transaction aborts it; strobes go inactive without waiting for CLK; no ack issued.
- Write: wreq sampled at edge E → wack high in cycle E+WR_CYC+2 (4 cycles at default); next grant possible at edge after IDLE cycle → minimum write period WR_CYC+3.
- Read: rreq sampled at edge E → rack and rdata valid in cycle E+RD_CYC+1 (3 at default); minimum read period RD_CYC+2.
- busy rises the cycle after grant edge, falls with return to IDLE.

## Configuration
- SRAM_ARB_STARVE_EN defined: counter of consecutive write grants, incremented on each write grant while rreq high, cleared on any read grant or when rreq low in IDLE. When counter = MAX_WBURST and rreq high, read wins even if wreq high.
- Not defined: strict write priority; reads proceed only when wreq low in IDLE; MAX_WBURST unused, no counter logic.

## Test plan
- Reset mid-WPULSE (wr=0) → wr, enout1 return to 1 asynchronously; state IDLE; no wack.
- Write wbank=0, waddr=0x7FF, wdata=0xA5 → WSETUP 1 cycle, wr low 2 cycles, enout1 low 4 cycles, enout2 high throughout, wack in 4th cycle; SRAM model holds 0xA5 at 0x7FF.
- Read rbank=0, raddr=0x7FF after above → rd low 2 cycles, rack 3 cycles after grant, rdata=0xA5; bank 1 same address reads its own contents.
- wreq and rreq raised same cycle, one each → write granted first, read after one IDLE cycle; wr/rd never overlap.
- wreq held continuously with rreq high: guard build → read granted after exactly 4 writes; non-guard build → no rack until wreq drops.
